// File: rtl/noc_pkg.sv
// ============================================================================
// Module : noc_pkg
// Brief  : Shared types, port indices and route function for the NoC route stage.
//          Route order is selected by the RC_YX_ORDER_EN macro (XY when undefined).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package noc_pkg;

  typedef enum logic [1:0] {
    FT_HEAD     = 2'b00,
    FT_BODY     = 2'b01,
    FT_TAIL     = 2'b10,
    FT_HEADTAIL = 2'b11
  } flit_type_e;

  localparam int P_N       = 0;
  localparam int P_E       = 1;
  localparam int P_S       = 2;
  localparam int P_W       = 3;
  localparam int P_L       = 4;
  localparam int NUM_PORTS = 5;

  // Coordinates are zero-extended to this width so one function serves any X_W/Y_W up to 16.
  localparam int COORD_W = 16;

  typedef logic [COORD_W-1:0]   coord_t;
  typedef logic [NUM_PORTS-1:0] port_oh_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } mesh_addr_t;

  function automatic port_oh_t route_calc(input mesh_addr_t dest, input mesh_addr_t own);
    port_oh_t p;
    p = '0;
`ifdef RC_YX_ORDER_EN
    if (dest.y > own.y)      p[P_N] = 1'b1;
    else if (dest.y < own.y) p[P_S] = 1'b1;
    else if (dest.x > own.x) p[P_E] = 1'b1;
    else if (dest.x < own.x) p[P_W] = 1'b1;
    else                     p[P_L] = 1'b1;
`else
    if (dest.x > own.x)      p[P_E] = 1'b1;
    else if (dest.x < own.x) p[P_W] = 1'b1;
    else if (dest.y > own.y) p[P_N] = 1'b1;
    else if (dest.y < own.y) p[P_S] = 1'b1;
    else                     p[P_L] = 1'b1;
`endif
    return p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/noc_route_compute_if.sv
// ============================================================================
// Module : noc_route_compute_if
// Brief  : Flit in/out handshake bundle around the route-computation stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface noc_route_compute_if
  import noc_pkg::*;
#(
  parameter int DATA_W = 32
);

  logic                 in_valid;
  logic [1:0]           in_type;
  logic [DATA_W-1:0]    in_data;
  logic                 in_ready;
  logic                 out_valid;
  logic [1:0]           out_type;
  logic [DATA_W-1:0]    out_data;
  logic [NUM_PORTS-1:0] out_port;
  logic                 out_ready;

  // master: the surrounding buffer/allocator; slave: the route stage itself
  modport master (
    output in_valid, in_type, in_data, out_ready,
    input  in_ready, out_valid, out_type, out_data, out_port
  );

  modport slave (
    input  in_valid, in_type, in_data, out_ready,
    output in_ready, out_valid, out_type, out_data, out_port
  );

endinterface

`default_nettype wire

// File: rtl/noc_route_compute.sv
// ============================================================================
// Module : noc_route_compute
// Brief  : Wormhole route-computation stage with one-cycle registered output.
//          Define RC_YX_ORDER_EN for YX dimension order (default XY).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module noc_route_compute
  import noc_pkg::*;
#(
  parameter int X_W    = 4,
  parameter int Y_W    = 4,
  parameter int DATA_W = 32
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  input  wire logic [X_W-1:0] own_x_i,
  input  wire logic [Y_W-1:0] own_y_i,
  noc_route_compute_if.slave  flit_if,
  output logic                err_o
);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_e;

  state_e            state_q;
  port_oh_t          lock_q;
  port_oh_t          out_port_q;
  logic              out_valid_q;
  logic [1:0]        out_type_q;
  logic [DATA_W-1:0] out_data_q;
  logic              err_q;

  flit_type_e in_type;
  mesh_addr_t dest_addr;
  mesh_addr_t own_addr;
  port_oh_t   route_d;
  logic       in_ready;
  logic       accept;

  assign in_type  = flit_type_e'(flit_if.in_type);
  assign in_ready = !out_valid_q || flit_if.out_ready;
  assign accept   = flit_if.in_valid && in_ready;

  always_comb begin
    dest_addr.x = COORD_W'(flit_if.in_data[X_W-1:0]);
    dest_addr.y = COORD_W'(flit_if.in_data[X_W+Y_W-1:X_W]);
    own_addr.x  = COORD_W'(own_x_i);
    own_addr.y  = COORD_W'(own_y_i);
    route_d     = route_calc(dest_addr, own_addr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      lock_q      <= '0;
      out_port_q  <= '0;
      out_valid_q <= 1'b0;
      out_type_q  <= '0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (flit_if.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (accept) begin
        case (state_q)
          S_IDLE: begin
            case (in_type)
              FT_HEAD: begin
                lock_q      <= route_d;
                out_port_q  <= route_d;
                out_valid_q <= 1'b1;
                out_type_q  <= flit_if.in_type;
                out_data_q  <= flit_if.in_data;
                state_q     <= S_ACTIVE;
              end
              FT_HEADTAIL: begin
                out_port_q  <= route_d;
                out_valid_q <= 1'b1;
                out_type_q  <= flit_if.in_type;
                out_data_q  <= flit_if.in_data;
              end
              // Orphan BODY/TAIL: consume and drop so the input buffer cannot stall
              default: begin
                err_q <= 1'b1;
              end
            endcase
          end
          default: begin
            out_port_q  <= lock_q;
            out_valid_q <= 1'b1;
            out_type_q  <= flit_if.in_type;
            out_data_q  <= flit_if.in_data;
            if (in_type == FT_HEAD || in_type == FT_HEADTAIL) begin
              err_q <= 1'b1;
            end
            if (in_type == FT_TAIL || in_type == FT_HEADTAIL) begin
              state_q <= S_IDLE;
            end
          end
        endcase
      end
    end
  end

  assign flit_if.in_ready  = in_ready;
  assign flit_if.out_valid = out_valid_q;
  assign flit_if.out_type  = out_type_q;
  assign flit_if.out_data  = out_data_q;
  assign flit_if.out_port  = out_port_q;
  assign err_o             = err_q;

endmodule

`default_nettype wire

// File: tb/tb_noc_route_compute.sv
// ============================================================================
// Module : tb_noc_route_compute
// Brief  : Directed and randomized self-checking bench for noc_route_compute.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_noc_route_compute;

  localparam logic [1:0] T_HEAD = 2'b00;
  localparam logic [1:0] T_BODY = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_HT   = 2'b11;

  localparam logic [4:0] PORT_N = 5'b00001;
  localparam logic [4:0] PORT_E = 5'b00010;
  localparam logic [4:0] PORT_S = 5'b00100;
  localparam logic [4:0] PORT_W = 5'b01000;
  localparam logic [4:0] PORT_L = 5'b10000;

  typedef struct {
    logic [1:0]  ftype;
    logic [31:0] data;
    logic [4:0]  port;
  } exp_flit_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] own_x;
  logic [3:0] own_y;
  logic       err;

  noc_route_compute_if #(.DATA_W(32)) flit_if ();

  noc_route_compute #(.X_W(4), .Y_W(4), .DATA_W(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .own_x_i (own_x),
    .own_y_i (own_y),
    .flit_if (flit_if),
    .err_o   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  // Reference model: packet-level view plus a queue of flits owed to the output
  exp_flit_t  exp_q[$];
  bit         m_active;
  logic [4:0] m_lock;
  logic       exp_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] ref_route(input logic [31:0] d, input int ox, input int oy);
    int step_x;
    int step_y;
    step_x = int'(d[3:0]) - ox;
    step_y = int'(d[7:4]) - oy;
`ifdef RC_YX_ORDER_EN
    if (step_y != 0) return (step_y > 0) ? PORT_N : PORT_S;
    if (step_x != 0) return (step_x > 0) ? PORT_E : PORT_W;
`else
    if (step_x != 0) return (step_x > 0) ? PORT_E : PORT_W;
    if (step_y != 0) return (step_y > 0) ? PORT_N : PORT_S;
`endif
    return PORT_L;
  endfunction

  function automatic logic [31:0] mk(input int x, input int y);
    logic [31:0] r;
    r = $urandom();
    r[3:0] = 4'(x);
    r[7:4] = 4'(y);
    return r;
  endfunction

  task automatic model_accept(input logic [1:0] t, input logic [31:0] d);
    exp_flit_t f;
    f.ftype = t;
    f.data  = d;
    if (!m_active) begin
      if (t == T_HEAD || t == T_HT) begin
        f.port = ref_route(d, int'(own_x), int'(own_y));
        exp_q.push_back(f);
        if (t == T_HEAD) begin
          m_active = 1'b1;
          m_lock   = f.port;
        end
      end else begin
        exp_err = 1'b1;
      end
    end else begin
      if (t == T_HEAD || t == T_HT) exp_err = 1'b1;
      f.port = m_lock;
      exp_q.push_back(f);
      if (t == T_TAIL || t == T_HT) m_active = 1'b0;
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", flit_if.out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("out_type", flit_if.out_type, exp_q[0].ftype);
      chk("out_data", flit_if.out_data, exp_q[0].data);
      chk("out_port", flit_if.out_port, exp_q[0].port);
    end
    chk("err", err, exp_err);
  endtask

  // One clock cycle: drive, check ready at negedge, update model, check outputs after the edge.
  task automatic cyc(input logic v, input logic [1:0] t, input logic [31:0] d,
                     input logic rdy, output logic accepted);
    flit_if.in_valid  = v;
    flit_if.in_type   = t;
    flit_if.in_data   = d;
    flit_if.out_ready = rdy;
    @(negedge clk);
    chk("in_ready", flit_if.in_ready, (exp_q.size() == 0) || rdy);
    accepted = v && flit_if.in_ready;
    exp_err  = 1'b0;
    if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
    if (accepted) model_accept(t, d);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    logic        acc;
    logic [1:0]  h_type;
    logic [31:0] h_data;
    logic [1:0]  s_type;
    logic [31:0] s_data;
    logic [4:0]  s_port;
    logic        hold;
    int          r;

    m_active = 1'b0;
    m_lock   = '0;
    exp_err  = 1'b0;
    rst_n    = 1'b0;
    own_x    = 4'd2;
    own_y    = 4'd3;
    flit_if.in_valid  = 1'b0;
    flit_if.in_type   = '0;
    flit_if.in_data   = '0;
    flit_if.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", flit_if.out_valid, 1'b0);
    chk("rst_out_port",  flit_if.out_port, 5'b0);
    chk("rst_out_type",  flit_if.out_type, 2'b0);
    chk("rst_out_data",  flit_if.out_data, 32'b0);
    chk("rst_err",       err, 1'b0);
    rst_n = 1'b1;

    // 1: HEADTAIL east
    cyc(1, T_HT, mk(5, 3), 1, acc);
    chk("t1_port_E", flit_if.out_port, PORT_E);
    cyc(0, T_BODY, 32'h0, 1, acc);

    // 2: HEAD/BODY/TAIL south, own address changes after head
    cyc(1, T_HEAD, mk(2, 1), 1, acc);
    chk("t2_head_S", flit_if.out_port, PORT_S);
    own_x = 4'd0;
    own_y = 4'd0;
    cyc(1, T_BODY, $urandom(), 1, acc);
    chk("t2_body_S", flit_if.out_port, PORT_S);
    cyc(1, T_TAIL, $urandom(), 1, acc);
    chk("t2_tail_S", flit_if.out_port, PORT_S);

    // 3: local and order-dependent corner
    own_x = 4'd2;
    own_y = 4'd3;
    cyc(1, T_HT, mk(2, 3), 1, acc);
    chk("t3_local", flit_if.out_port, PORT_L);
    cyc(1, T_HT, mk(0, 7), 1, acc);
`ifdef RC_YX_ORDER_EN
    chk("t3_order", flit_if.out_port, PORT_N);
`else
    chk("t3_order", flit_if.out_port, PORT_W);
`endif

    // 4: back-pressure hold then release
    cyc(1, T_HEAD, mk(5, 3), 1, acc);
    cyc(1, T_BODY, $urandom(), 0, acc);
    s_type = flit_if.out_type;
    s_data = flit_if.out_data;
    s_port = flit_if.out_port;
    h_data = $urandom();
    for (int i = 0; i < 4; i++) begin
      cyc(1, T_TAIL, h_data, 0, acc);
      chk("t4_ready_low", acc, 1'b0);
      chk("t4_hold_type", flit_if.out_type, s_type);
      chk("t4_hold_data", flit_if.out_data, s_data);
      chk("t4_hold_port", flit_if.out_port, s_port);
    end
    cyc(1, T_TAIL, h_data, 1, acc);
    chk("t4_release_acc", acc, 1'b1);
    cyc(0, T_BODY, 32'h0, 1, acc);

    // 5: protocol errors
    cyc(1, T_BODY, $urandom(), 1, acc);
    chk("t5_orphan_err", err, 1'b1);
    chk("t5_orphan_drop", flit_if.out_valid, 1'b0);
    cyc(0, T_BODY, 32'h0, 1, acc);
    chk("t5_err_pulse", err, 1'b0);
    cyc(1, T_HEAD, mk(5, 3), 1, acc);
    cyc(1, T_HEAD, mk(0, 0), 1, acc);
    chk("t5_head_err", err, 1'b1);
    chk("t5_head_port", flit_if.out_port, PORT_E);
    cyc(1, T_TAIL, $urandom(), 1, acc);

    // 6: reset mid-packet
    cyc(1, T_HEAD, mk(5, 3), 0, acc);
    flit_if.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", flit_if.out_valid, 1'b0);
    chk("t6_rst_port",  flit_if.out_port, 5'b0);
    exp_q.delete();
    m_active = 1'b0;
    exp_err  = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1, T_HEAD, mk(2, 1), 1, acc);
    chk("t6_after_rst", flit_if.out_port, PORT_S);
    cyc(1, T_TAIL, $urandom(), 1, acc);

    // Randomized traffic against the model
    hold = 1'b0;
    h_type = T_HEAD;
    h_data = '0;
    for (int i = 0; i < 600; i++) begin
      if (!hold) begin
        r = $urandom_range(0, 99);
        if (m_active) h_type = (r < 6) ? T_HEAD : (r < 10) ? T_HT : (r < 65) ? T_BODY : T_TAIL;
        else          h_type = (r < 8) ? T_BODY : (r < 12) ? T_TAIL : (r < 55) ? T_HEAD : T_HT;
        h_data = $urandom();
        if ($urandom_range(0, 9) == 0) begin
          own_x = 4'($urandom_range(0, 15));
          own_y = 4'($urandom_range(0, 15));
        end
      end
      r = $urandom_range(0, 99);
      cyc(r < 80, h_type, h_data, $urandom_range(0, 99) < 70, acc);
      hold = (r < 80) && !acc;
    end

    cyc(0, T_BODY, 32'h0, 1, acc);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
